// File: rtl/xor_share_arb_pkg.sv
// Shared types and defaults for the round-robin XOR datapath controller.
// Also provides the index-width helper used for pointer and grant registers.
package xor_share_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_W      = 8;
  localparam int DEF_SETTLE = 2;

  // Never returns 0, so a single-entry range still gets a 1-bit register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xor_share_arb_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo N. Usable by any shared-resource controller.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // One spare bit so ptr + k never overflows before the modulo fold.
  logic [IW:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (!any && req[pos]) begin
        any      = 1'b1;
        idx      = pos[IW-1:0];
        gnt[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xor_share_arb.sv
// Shares one external XOR datapath among N_REQ requesters: accept one operand
// pair, hold it SETTLE cycles for the gate network to settle, then capture.
module xor_share_arb
  import xor_share_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int W      = DEF_W,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_y,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_z,
  output logic [W-1:0]       dp_x,
  output logic [W-1:0]       dp_y,
  input  logic [W-1:0]       dp_z,
  output logic               busy
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = idx_w(SETTLE);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [W-1:0]     dp_x_q, dp_x_d;
  logic [W-1:0]     dp_y_q, dp_y_d;
  logic [W-1:0]     rsp_z_q, rsp_z_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [N_REQ-1:0] ready_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic [W-1:0] x_arr [N_REQ];
  logic [W-1:0] y_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign x_arr[gi] = req_x[gi*W +: W];
    assign y_arr[gi] = req_y[gi*W +: W];
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    dp_x_d      = dp_x_q;
    dp_y_d      = dp_y_q;
    rsp_z_d     = rsp_z_q;
    rsp_valid_d = '0;
    ready_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          ready_d = pick_gnt;
          dp_x_d  = x_arr[pick_idx];
          dp_y_d  = y_arr[pick_idx];
          gnt_d   = pick_idx;
          ptr_d   = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
          cnt_d   = CNT_INIT;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CAPTURE: begin
        rsp_z_d     = dp_z;
        rsp_valid_d = N_REQ'(1) << gnt_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      dp_x_q      <= '0;
      dp_y_q      <= '0;
      rsp_z_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      dp_x_q      <= dp_x_d;
      dp_y_q      <= dp_y_d;
      rsp_z_q     <= rsp_z_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // The state register idles in IDLE during reset, so the strobe is masked
  // to keep requesters from seeing an accept that will never take effect.
  assign req_ready = ready_d & {N_REQ{rst_n}};
  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = rsp_z_q;
  assign dp_x      = dp_x_q;
  assign dp_y      = dp_y_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xor_share_arb.sv
// Self-checking bench for xor_share_arb: vector table of grant/result cases
// plus reset and back-to-back sequences, responses checked via a scoreboard.
module tb_xor_share_arb;

  localparam int N      = 4;
  localparam int W      = 8;
  localparam int SETTLE = 2;
  localparam int LAT    = SETTLE + 2;
  localparam int NV     = 11;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_z;
  logic [W-1:0]   dp_x;
  logic [W-1:0]   dp_y;
  logic [W-1:0]   dp_z;
  logic           busy;

  xor_share_arb #(.N_REQ(N), .W(W), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_z     (rsp_z),
    .dp_x      (dp_x),
    .dp_y      (dp_y),
    .dp_z      (dp_z),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: result only becomes correct two edges after operands change.
  logic [W-1:0] z1 = '0;
  logic [W-1:0] z2 = '0;
  always @(posedge clk) begin
    z1 <= dp_x ^ dp_y;
    z2 <= z1;
  end
  assign dp_z = z2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] x;
    logic [N*W-1:0] y;
    logic [N-1:0]   gnt;
    logic [W-1:0]   z;
  } vec_t;

  typedef struct {
    logic [N-1:0] oh;
    logic [W-1:0] z;
    int           cyc;
  } sb_t;

  vec_t vecs [NV];
  sb_t  sb_q [$];

  int checks = 0;
  int errors = 0;

  logic         have_prev = 1'b0;
  logic [W-1:0] exp_dx = '0;
  logic [W-1:0] exp_dy = '0;
  int           last_acc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] sl(input logic [N*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  function automatic int oh2i(input logic [N-1:0] oh);
    int r = 0;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    sb_t e;
    if (rst_n && rsp_valid != '0) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", {60'd0, rsp_valid}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        $display("RSP cyc=%0d oh=%b z=%h", cyc, rsp_valid, rsp_z);
        chk("rsp_valid", {60'd0, rsp_valid}, {60'd0, e.oh});
        chk("rsp_z", {56'd0, rsp_z}, {56'd0, e.z});
        chk("rsp_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
      if (have_prev && k < 3) begin
        chk("hold_busy", {63'd0, busy}, 64'd1);
        chk("hold_dp_x", {56'd0, dp_x}, {56'd0, exp_dx});
        chk("hold_dp_y", {56'd0, dp_y}, {56'd0, exp_dy});
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input vec_t v, input bit push);
    logic ok;
    int   g;
    sb_t  e;
    req_valid = v.valid;
    req_x     = v.x;
    req_y     = v.y;
    wait_ready(ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=%b", v.gnt);
      req_valid = '0;
      return;
    end
    chk("req_ready", {60'd0, req_ready}, {60'd0, v.gnt});
    if (have_prev) begin
      chk("b2b_dp_x_old", {56'd0, dp_x}, {56'd0, exp_dx});
      chk("accept_spacing", 64'(cyc - last_acc), 64'(LAT));
    end
    g = oh2i(v.gnt);
    $display("ACC cyc=%0d valid=%b ready=%b x=%h y=%h", cyc, v.valid, req_ready, sl(v.x, g), sl(v.y, g));
    if (push) begin
      e.oh  = v.gnt;
      e.z   = v.z;
      e.cyc = cyc + LAT;
      sb_q.push_back(e);
    end
    exp_dx    = sl(v.x, g);
    exp_dy    = sl(v.y, g);
    last_acc  = cyc;
    have_prev = 1'b1;
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  task automatic chk_zero(input string name);
    chk(name, {31'd0, req_ready, rsp_valid, rsp_z, dp_x, dp_y, busy}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] vm [NV] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                              4'b0010, 4'b0100, 4'b1001, 4'b0001, 4'b1100, 4'b0110};
    logic [N-1:0] gm [NV] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                              4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b0010};
    vec_t v;

    for (int r = 0; r < NV; r++) begin
      vecs[r].valid = vm[r];
      vecs[r].gnt   = gm[r];
      vecs[r].x     = 32'($urandom);
      vecs[r].y     = 32'($urandom);
    end
    vecs[5].x[15:8] = 8'hA5;
    vecs[5].y[15:8] = 8'h0F;
    for (int r = 0; r < NV; r++) begin
      vecs[r].z = sl(vecs[r].x, oh2i(vecs[r].gnt)) ^ sl(vecs[r].y, oh2i(vecs[r].gnt));
    end
    vecs[5].z = 8'hAA;

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      req_valid = 4'($urandom);
      req_x     = 32'($urandom);
      req_y     = 32'($urandom);
      @(negedge clk);
      chk_zero("reset_outputs");
    end

    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_ready", {60'd0, req_ready}, 64'd0);
      @(posedge clk);
      #1;
    end

    for (int r = 0; r < NV; r++) begin
      run_op(vecs[r], 1'b1);
    end

    // Op for requester 1 is killed by reset during HOLD; ptr would otherwise be 2.
    v       = vecs[5];
    v.valid = 4'b0010;
    v.gnt   = 4'b0010;
    run_op(v, 1'b0);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_zero("midop_reset_outputs");
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    have_prev = 1'b0;
    v         = vecs[0];
    v.valid   = 4'b1111;
    v.gnt     = 4'b0001;
    v.z       = sl(v.x, 0) ^ sl(v.y, 0);
    run_op(v, 1'b1);

    repeat (8) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
